mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory bus between the pipeline's instruction fetch and its data load/store.
//  Sits between the pipeline and the memory.
//  Its per-requester response strobes drive the pipeline's inst_available and data_available inputs.
//  At most one transaction is outstanding on the memory bus at a time.
// PARAMETERS
//  ADDR_WIDTH  32  address width for all requesters and the memory bus
//  DATA_WIDTH  32  data width; the write mask is DATA_WIDTH/8 bits
// PORTS
//  clock           in   1      system clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  inst_req_valid  in   1      fetch request
//  inst_req_addr   in   AW     fetch address
//  inst_req_ready  out  1      fetch request accepted this cycle
//  inst_rsp_valid  out  1      fetch data valid (1 cycle)
//  inst_rsp_data   out  DW     fetched word
//  data_req_valid  in   1      load/store request
//  data_req_write  in   1      1 = store, 0 = load
//  data_req_addr   in   AW     data address
//  data_req_wdata  in   DW     store data
//  data_req_wmask  in   DW/8   store byte enables
//  data_req_ready  out  1      data request accepted this cycle
//  data_rsp_valid  out  1      load data valid / store done (1 cycle)
//  data_rsp_rdata  out  DW     load data
//  mem_req_valid   out  1      request to memory
//  mem_req_write   out  1      store flag
//  mem_req_addr    out  AW     latched address
//  mem_req_wdata   out  DW     latched store data
//  mem_req_wmask   out  DW/8   latched byte enables
//  mem_req_ready   in   1      memory accepts the request
//  mem_rsp_valid   in   1      memory response, for both reads and writes
//  mem_rsp_rdata   in   DW     read data
// BEHAVIOUR
//  FSM IDLE -> REQ -> RESP -> IDLE. The owner register (INST/DATA) names the requester being served.
//  IDLE:
//   - Grant exactly one requester whose valid is high.
//   - Assert its *_req_ready combinationally in the same cycle.
//   - Latch addr/wdata/wmask/write and the owner.
//   - Go to REQ. With no valid request, stay in IDLE.
//  REQ:
//   - mem_req_valid = 1, with latched fields held stable.
//   - Stay in REQ until mem_req_ready = 1, then go to RESP.
//  RESP:
//   - Wait for mem_rsp_valid.
//   - In that cycle, the owner's *_rsp_valid = 1 and its rsp data = mem_rsp_rdata, passed through combinationally.
//   - Then go to IDLE.
//  Non-owner rsp_valid is always 0. *_req_ready is 0 outside IDLE.
//  Minimum latency, accept to response: 2 cycles (accept in c0, mem handshake in c1, rsp in c2).
//  Back-to-back requests: the next grant is possible in the cycle after the response.
//  Default priority, both valid in IDLE: data wins.
//   - Fetch may starve while data requests continue.
//   - This is tolerated because the pipeline stalls fetch on a data access.
//  Out-of-protocol inputs:
//   - mem_rsp_valid in IDLE or REQ is ignored.
//   - mem_req_ready outside REQ is ignored.
//  Reset (asynchronous, any state):
//   - State = IDLE, owner = INST, last_grant = INST, latched fields = 0.
//   - All outputs are 0.
//   - An in-flight transaction is abandoned; its later response arrives in IDLE and is dropped.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined:
//   - A last_grant flop (reset INST) is updated on every grant.
//   - When both requesters are valid in IDLE, the grant goes to the requester NOT granted last.
//   - A single requester is always granted immediately.
//  MEM_ARB_ROUND_ROBIN_EN undefined:
//   - Fixed data-over-inst priority.
//   - The last_grant flop is absent.
// STRUCTURE
//  Package mem_arb_pkg:
//   - enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_RESP}
//   - enum arb_owner_t {OWNER_INST, OWNER_DATA}
//  Sub-module mem_arb_grant (combinational): inputs the two valids and last_grant; outputs grant_inst and grant_data.
//  mem_arb_grant holds all priority/round-robin logic, selected by the macro.
// TESTING
//  1. Fetch only, inst addr 0x100, mem ready immediately, rsp 0xDEADBEEF one cycle later:
//     inst_req_ready in c0, mem_req_valid in c1, inst_rsp_valid=1 with data 0xDEADBEEF in c2.
//  2. Both valid in the same IDLE cycle, default build:
//     data_req_ready=1, inst_req_ready=0; fetch is served in the next transaction.
//  3. Both valid continuously, MEM_ARB_ROUND_ROBIN_EN defined:
//     grants alternate INST, DATA, INST, DATA...
//  4. Store 0x12345678 with mask 4'b0011, mem_req_ready low for 3 cycles:
//     mem_req_* held stable all 3 cycles; then data_rsp_valid pulses once; inst_rsp_valid stays 0.
//  5. reset_n pulsed low while in RESP, late mem_rsp_valid after release:
//     all outputs 0 during reset; no *_rsp_valid for the stale response; a new fetch is granted normally.
//  6. Spurious mem_rsp_valid in IDLE and during REQ:
//     no rsp_valid output and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } arb_owner_t;

  // Maps a data-side grant onto the owner encoding.
  function automatic arb_owner_t owner_of_grant(input logic grant_data);
    if (grant_data) begin
      owner_of_grant = OWNER_DATA;
    end else begin
      owner_of_grant = OWNER_INST;
    end
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and load/store. MEM_ARB_ROUND_ROBIN_EN selects
// alternating grants under contention; otherwise data always beats fetch.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic inst_valid,
  input  logic data_valid,
  input  logic last_grant,
  output logic grant_inst,
  output logic grant_data
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Contention goes to whichever requester was not served last
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (inst_valid && data_valid) begin
      if (last_grant == OWNER_DATA) begin
        grant_inst = 1'b1;
      end else begin
        grant_data = 1'b1;
      end
    end else if (data_valid) begin
      grant_data = 1'b1;
    end else if (inst_valid) begin
      grant_inst = 1'b1;
    end else begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  // Fixed priority: fetch may starve while loads/stores keep coming
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (data_valid) begin
      grant_data = 1'b1;
    end else if (inst_valid) begin
      grant_inst = 1'b1;
    end else begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory bus between instruction fetch and data
// load/store. Build with MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    inst_req_valid,
  input  logic [ADDR_WIDTH-1:0]   inst_req_addr,
  output logic                    inst_req_ready,
  output logic                    inst_rsp_valid,
  output logic [DATA_WIDTH-1:0]   inst_rsp_data,
  input  logic                    data_req_valid,
  input  logic                    data_req_write,
  input  logic [ADDR_WIDTH-1:0]   data_req_addr,
  input  logic [DATA_WIDTH-1:0]   data_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_req_wmask,
  output logic                    data_req_ready,
  output logic                    data_rsp_valid,
  output logic [DATA_WIDTH-1:0]   data_rsp_rdata,
  output logic                    mem_req_valid,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);

  arb_state_t                r_state;
  arb_owner_t                r_owner;
  logic                      r_mem_req_valid;
  logic                      r_mem_req_write;
  logic [ADDR_WIDTH-1:0]     r_mem_req_addr;
  logic [DATA_WIDTH-1:0]     r_mem_req_wdata;
  logic [DATA_WIDTH/8-1:0]   r_mem_req_wmask;

  logic w_last_grant;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_idle;
  logic w_take_inst;
  logic w_take_data;
  logic w_rsp_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t r_last_grant;

  // Remembers who won the most recent grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= OWNER_INST;
    end else if (w_take_inst || w_take_data) begin
      r_last_grant <= owner_of_grant(w_take_data);
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = OWNER_INST;
`endif

  mem_arb_grant u_grant (
    .inst_valid (inst_req_valid),
    .data_valid (data_req_valid),
    .last_grant (w_last_grant),
    .grant_inst (w_grant_inst),
    .grant_data (w_grant_data)
  );

  // reset_n gating keeps the ready strobes low while reset is held
  assign w_idle      = reset_n && (r_state == ARB_IDLE);
  assign w_take_inst = w_idle && w_grant_inst;
  assign w_take_data = w_idle && w_grant_data;
  assign w_rsp_fire  = (r_state == ARB_RESP) && mem_rsp_valid;

  assign inst_req_ready = w_take_inst;
  assign data_req_ready = w_take_data;

  assign inst_rsp_valid = w_rsp_fire && (r_owner == OWNER_INST);
  assign data_rsp_valid = w_rsp_fire && (r_owner == OWNER_DATA);
  assign inst_rsp_data  = inst_rsp_valid ? mem_rsp_rdata : '0;
  assign data_rsp_rdata = data_rsp_valid ? mem_rsp_rdata : '0;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_write = r_mem_req_write;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_wdata = r_mem_req_wdata;
  assign mem_req_wmask = r_mem_req_wmask;

  // Transaction FSM: grant and latch, memory handshake, response wait
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ARB_IDLE;
      r_owner         <= OWNER_INST;
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_wmask <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_take_data) begin
            r_owner         <= OWNER_DATA;
            r_mem_req_write <= data_req_write;
            r_mem_req_addr  <= data_req_addr;
            r_mem_req_wdata <= data_req_wdata;
            r_mem_req_wmask <= data_req_wmask;
            r_mem_req_valid <= 1'b1;
            r_state         <= ARB_REQ;
          end else if (w_take_inst) begin
            r_owner         <= OWNER_INST;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= inst_req_addr;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= ARB_REQ;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= ARB_RESP;
          end else begin
            r_state <= ARB_REQ;
          end
        end
        ARB_RESP: begin
          if (mem_rsp_valid) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_RESP;
          end
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the memory side is driven by hand.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        inst_req_valid;
  logic [31:0] inst_req_addr;
  logic        inst_req_ready;
  logic        inst_rsp_valid;
  logic [31:0] inst_rsp_data;
  logic        data_req_valid;
  logic        data_req_write;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_wdata;
  logic [3:0]  data_req_wmask;
  logic        data_req_ready;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .inst_req_valid (inst_req_valid),
    .inst_req_addr  (inst_req_addr),
    .inst_req_ready (inst_req_ready),
    .inst_rsp_valid (inst_rsp_valid),
    .inst_rsp_data  (inst_rsp_data),
    .data_req_valid (data_req_valid),
    .data_req_write (data_req_write),
    .data_req_addr  (data_req_addr),
    .data_req_wdata (data_req_wdata),
    .data_req_wmask (data_req_wmask),
    .data_req_ready (data_req_ready),
    .data_rsp_valid (data_rsp_valid),
    .data_rsp_rdata (data_rsp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_outputs_zero(input string tag);
    chk({tag, ".inst_req_ready"}, 64'(inst_req_ready), 64'd0);
    chk({tag, ".data_req_ready"}, 64'(data_req_ready), 64'd0);
    chk({tag, ".inst_rsp_valid"}, 64'(inst_rsp_valid), 64'd0);
    chk({tag, ".data_rsp_valid"}, 64'(data_rsp_valid), 64'd0);
    chk({tag, ".inst_rsp_data"},  64'(inst_rsp_data),  64'd0);
    chk({tag, ".data_rsp_rdata"}, 64'(data_rsp_rdata), 64'd0);
    chk({tag, ".mem_req_valid"},  64'(mem_req_valid),  64'd0);
    chk({tag, ".mem_req_write"},  64'(mem_req_write),  64'd0);
    chk({tag, ".mem_req_addr"},   64'(mem_req_addr),   64'd0);
    chk({tag, ".mem_req_wdata"},  64'(mem_req_wdata),  64'd0);
    chk({tag, ".mem_req_wmask"},  64'(mem_req_wmask),  64'd0);
  endtask

  logic exp_data_grant;

  initial begin
    reset_n        = 1'b0;
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_0040;
    data_req_valid = 1'b1;
    data_req_write = 1'b1;
    data_req_addr  = 32'h0000_0080;
    data_req_wdata = 32'h5555_AAAA;
    data_req_wmask = 4'hF;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b1;
    mem_rsp_rdata  = 32'h7777_7777;

    // Reset held with every input active: all outputs stay 0
    #12;
    check_all_outputs_zero("reset");
    next_cycle();
    reset_n        = 1'b1;
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    data_req_write = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    #2;
    chk("post_reset.mem_req_valid", 64'(mem_req_valid), 64'd0);

    // Test 1: single fetch, minimum latency
    next_cycle();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_0100;
    #2;
    chk("t1.c0.inst_req_ready", 64'(inst_req_ready), 64'd1);
    chk("t1.c0.data_req_ready", 64'(data_req_ready), 64'd0);
    chk("t1.c0.mem_req_valid",  64'(mem_req_valid),  64'd0);
    next_cycle();
    inst_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #2;
    chk("t1.c1.mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t1.c1.mem_req_addr",  64'(mem_req_addr),  64'h100);
    chk("t1.c1.mem_req_write", 64'(mem_req_write), 64'd0);
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    #2;
    chk("t1.c2.mem_req_valid",  64'(mem_req_valid),  64'd0);
    chk("t1.c2.inst_rsp_valid", 64'(inst_rsp_valid), 64'd1);
    chk("t1.c2.inst_rsp_data",  64'(inst_rsp_data),  64'hDEAD_BEEF);
    chk("t1.c2.data_rsp_valid", 64'(data_rsp_valid), 64'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #2;
    chk("t1.c3.inst_rsp_valid", 64'(inst_rsp_valid), 64'd0);

    // Test 2: simultaneous requests, data wins, fetch follows right after
    next_cycle();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_0200;
    data_req_valid = 1'b1;
    data_req_write = 1'b0;
    data_req_addr  = 32'h0000_0300;
    #2;
    chk("t2.grant.data_req_ready", 64'(data_req_ready), 64'd1);
    chk("t2.grant.inst_req_ready", 64'(inst_req_ready), 64'd0);
    next_cycle();
    data_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #2;
    chk("t2.req.mem_req_addr",    64'(mem_req_addr),   64'h300);
    chk("t2.req.inst_req_ready",  64'(inst_req_ready), 64'd0);
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hA5A5_A5A5;
    #2;
    chk("t2.rsp.data_rsp_valid", 64'(data_rsp_valid), 64'd1);
    chk("t2.rsp.data_rsp_rdata", 64'(data_rsp_rdata), 64'hA5A5_A5A5);
    chk("t2.rsp.inst_rsp_valid", 64'(inst_rsp_valid), 64'd0);
    chk("t2.rsp.inst_req_ready", 64'(inst_req_ready), 64'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #2;
    chk("t2.b2b.inst_req_ready", 64'(inst_req_ready), 64'd1);
    next_cycle();
    inst_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #2;
    chk("t2.fetch.mem_req_addr", 64'(mem_req_addr), 64'h200);
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111_2222;
    #2;
    chk("t2.fetch.inst_rsp_valid", 64'(inst_rsp_valid), 64'd1);
    chk("t2.fetch.inst_rsp_data",  64'(inst_rsp_data),  64'h1111_2222);

    // Test 4 + 6: stalled store with a spurious response during REQ
    next_cycle();
    mem_rsp_valid  = 1'b0;
    data_req_valid = 1'b1;
    data_req_write = 1'b1;
    data_req_addr  = 32'h0000_0400;
    data_req_wdata = 32'h1234_5678;
    data_req_wmask = 4'b0011;
    #2;
    chk("t4.grant.data_req_ready", 64'(data_req_ready), 64'd1);
    next_cycle();
    data_req_valid = 1'b0;
    data_req_write = 1'b0;
    data_req_addr  = 32'h0000_0000;
    data_req_wdata = 32'hFFFF_FFFF;
    data_req_wmask = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = (i == 1);
      #2;
      chk($sformatf("t4.stall%0d.mem_req_valid", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("t4.stall%0d.mem_req_write", i), 64'(mem_req_write), 64'd1);
      chk($sformatf("t4.stall%0d.mem_req_addr", i),  64'(mem_req_addr),  64'h400);
      chk($sformatf("t4.stall%0d.mem_req_wdata", i), 64'(mem_req_wdata), 64'h1234_5678);
      chk($sformatf("t4.stall%0d.mem_req_wmask", i), 64'(mem_req_wmask), 64'h3);
      chk($sformatf("t4.stall%0d.data_rsp_valid", i), 64'(data_rsp_valid), 64'd0);
      chk($sformatf("t4.stall%0d.inst_rsp_valid", i), 64'(inst_rsp_valid), 64'd0);
      next_cycle();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    #2;
    chk("t4.accept.mem_req_valid", 64'(mem_req_valid), 64'd1);
    next_cycle();
    mem_req_ready = 1'b0;
    #2;
    chk("t4.wait.data_rsp_valid", 64'(data_rsp_valid), 64'd0);
    chk("t4.wait.mem_req_valid",  64'(mem_req_valid),  64'd0);
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0000;
    #2;
    chk("t4.done.data_rsp_valid", 64'(data_rsp_valid), 64'd1);
    chk("t4.done.inst_rsp_valid", 64'(inst_rsp_valid), 64'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    #2;
    chk("t4.after.data_rsp_valid", 64'(data_rsp_valid), 64'd0);

    // Test 6: spurious response in IDLE leaves the arbiter idle
    next_cycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD0_BAD0;
    #2;
    chk("t6.idle.inst_rsp_valid", 64'(inst_rsp_valid), 64'd0);
    chk("t6.idle.data_rsp_valid", 64'(data_rsp_valid), 64'd0);
    chk("t6.idle.mem_req_valid",  64'(mem_req_valid),  64'd0);
    next_cycle();
    mem_rsp_valid  = 1'b0;
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_0600;
    #2;
    chk("t6.still_idle.inst_req_ready", 64'(inst_req_ready), 64'd1);

    // Test 5: reset while in RESP, stale response afterwards is dropped
    next_cycle();
    inst_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    #2;
    chk("t5.in_resp.mem_req_valid", 64'(mem_req_valid), 64'd0);
    next_cycle();
    reset_n        = 1'b0;
    inst_req_valid = 1'b1;
    mem_rsp_valid  = 1'b1;
    mem_rsp_rdata  = 32'h5151_5151;
    #2;
    check_all_outputs_zero("t5.reset");
    next_cycle();
    reset_n        = 1'b1;
    inst_req_valid = 1'b0;
    #2;
    chk("t5.stale.inst_rsp_valid", 64'(inst_rsp_valid), 64'd0);
    chk("t5.stale.data_rsp_valid", 64'(data_rsp_valid), 64'd0);
    next_cycle();
    mem_rsp_valid  = 1'b0;
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_0500;
    #2;
    chk("t5.new.inst_req_ready", 64'(inst_req_ready), 64'd1);
    next_cycle();
    inst_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #2;
    chk("t5.new.mem_req_addr",  64'(mem_req_addr),  64'h500);
    chk("t5.new.mem_req_valid", 64'(mem_req_valid), 64'd1);
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    #2;
    chk("t5.new.inst_rsp_valid", 64'(inst_rsp_valid), 64'd1);
    chk("t5.new.inst_rsp_data",  64'(inst_rsp_data),  64'hCAFE_F00D);
    next_cycle();
    mem_rsp_valid = 1'b0;

    // Test 3: a lone fetch, then both requesters held valid continuously
    data_req_write = 1'b0;
    data_req_addr  = 32'h0000_0A00;
    inst_req_addr  = 32'h0000_0B00;
    for (int k = 0; k < 5; k++) begin
      inst_req_valid = 1'b1;
      data_req_valid = (k != 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_data_grant = (k % 2 == 1);
`else
      exp_data_grant = (k != 0);
`endif
      #2;
      chk($sformatf("t3.g%0d.data_req_ready", k), 64'(data_req_ready), 64'(exp_data_grant));
      chk($sformatf("t3.g%0d.inst_req_ready", k), 64'(inst_req_ready), 64'(!exp_data_grant));
      next_cycle();
      mem_req_ready = 1'b1;
      #2;
      chk($sformatf("t3.g%0d.mem_req_addr", k), 64'(mem_req_addr),
          exp_data_grant ? 64'hA00 : 64'hB00);
      next_cycle();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h0000_0100 + 32'(k);
      #2;
      chk($sformatf("t3.g%0d.data_rsp_valid", k), 64'(data_rsp_valid), 64'(exp_data_grant));
      chk($sformatf("t3.g%0d.inst_rsp_valid", k), 64'(inst_rsp_valid), 64'(!exp_data_grant));
      next_cycle();
      mem_rsp_valid = 1'b0;
    end
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
